// File: rtl/data_bus_ram_responder_pkg.sv
// Shared DataBus definitions: access/length encodings, responder state
// encoding, the default I/O window base and the request qualifier.
package data_bus_ram_responder_pkg;

    typedef enum logic [1:0] {
        ACC_NONE = 2'd0,
        ACC_R    = 2'd1,
        ACC_W    = 2'd2,
        ACC_X    = 2'd3
    } mem_access_t;

    typedef enum logic [1:0] {
        LEN_BYTE = 2'd0,
        LEN_HALF = 2'd1,
        LEN_WORD = 2'd2,
        LEN_RSVD = 2'd3
    } mem_len_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } db_state_t;

    localparam logic [31:0] DB_IO_BASE = 32'hFFFF_0000;

    // A transfer is a request only when something is asked for outside the I/O window.
    function automatic logic is_request(input mem_access_t acc, input logic io);
        return (acc != ACC_NONE) && !io;
    endfunction

endpackage

// File: rtl/data_bus_ram_responder_db_lane_align.sv
// Little-endian lane steering shared by the RAM and I/O responders.
// Write side: byte enables plus the write datum replicated onto every lane.
// Read side: selected lane(s) right-aligned and zero-extended.
module db_lane_align
    import data_bus_ram_responder_pkg::*;
(
    input  logic [1:0]  i_addr_lo,
    input  mem_len_t    i_len,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rword,
    output logic [3:0]  o_be,
    output logic [31:0] o_wword,
    output logic [31:0] o_rdata
);

    // Decode lane enables and steer write/read data by transfer size.
    always_comb begin
        o_be    = 4'b1111;
        o_wword = i_wdata;
        o_rdata = i_rword;
        case (i_len)
            LEN_BYTE: begin
                o_be    = 4'b0001 << i_addr_lo;
                o_wword = {4{i_wdata[7:0]}};
                case (i_addr_lo)
                    2'd0:    o_rdata = {24'd0, i_rword[7:0]};
                    2'd1:    o_rdata = {24'd0, i_rword[15:8]};
                    2'd2:    o_rdata = {24'd0, i_rword[23:16]};
                    2'd3:    o_rdata = {24'd0, i_rword[31:24]};
                    default: o_rdata = 32'd0;
                endcase
            end
            LEN_HALF: begin
                // addr[0] is ignored: the MMU owns misalignment faults.
                o_wword = {2{i_wdata[15:0]}};
                if (i_addr_lo[1]) begin
                    o_be    = 4'b1100;
                    o_rdata = {16'd0, i_rword[31:16]};
                end else begin
                    o_be    = 4'b0011;
                    o_rdata = {16'd0, i_rword[15:0]};
                end
            end
            LEN_WORD: begin
                o_be    = 4'b1111;
                o_wword = i_wdata;
                o_rdata = i_rword;
            end
            default: begin
                // Reserved length behaves as a full word.
                o_be    = 4'b1111;
                o_wword = i_wdata;
                o_rdata = i_rword;
            end
        endcase
    end

endmodule

// File: rtl/data_bus_ram_responder.sv
// DataBus responder for the on-chip word RAM. Accepts R/X/W requests outside
// the I/O window, inserts WAIT_CYCLES wait states and completes each transfer
// with a one-cycle db_ready pulse. Reads load db_dataOut on entry to the
// response cycle; writes commit at the edge that ends it.
module data_bus_ram_responder
    import data_bus_ram_responder_pkg::*;
#(
    parameter int          DEPTH_LOG2  = 12,
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] IO_BASE     = DB_IO_BASE
) (
    input  logic        clk,
    input  logic        res,
    input  logic [31:0] db_addr,
    input  logic [31:0] db_dataIn,
    output logic [31:0] db_dataOut,
    input  mem_access_t db_accessType,
    input  mem_len_t    db_memLen,
    output logic        db_ready,
    output logic        db_io
);

    localparam int         DEPTH     = 1 << DEPTH_LOG2;
    localparam int         AW        = DEPTH_LOG2 + 2;
    localparam logic [7:0] WAIT_INIT = (WAIT_CYCLES == 0) ? 8'd0 : 8'(WAIT_CYCLES - 1);

    db_state_t   r_state;
    db_state_t   w_state_nxt;
    logic [7:0]  r_cnt;
    logic [7:0]  w_cnt_nxt;
    logic [AW-1:0] r_addr;
    mem_len_t    r_len;
    logic        r_write;
    logic [31:0] r_wdata;
    logic        r_ready;
    logic [31:0] r_dout;
    logic [31:0] r_mem [0:DEPTH-1];

    logic          w_req;
    logic          w_latch;
    logic          w_enter_resp;
    logic          w_commit;
    logic          w_is_write;
    logic [AW-1:0] w_addr;
    mem_len_t      w_len;
    logic [DEPTH_LOG2-1:0] w_idx;
    logic [31:0]   w_rword;
    logic [3:0]    w_be;
    logic [31:0]   w_wword;
    logic [31:0]   w_rdata;

    assign db_io      = (db_addr >= IO_BASE);
    assign w_req      = is_request(db_accessType, db_io);

    // In IDLE the live bus is used so a zero-wait read can load data on
    // acceptance; afterwards the latched request is authoritative.
    assign w_addr     = (r_state == ST_IDLE) ? db_addr[AW-1:0] : r_addr;
    assign w_len      = (r_state == ST_IDLE) ? db_memLen : r_len;
    assign w_is_write = (r_state == ST_IDLE) ? (db_accessType == ACC_W) : r_write;
    assign w_idx      = w_addr[AW-1:2];
    assign w_rword    = r_mem[w_idx];
    assign w_commit   = (r_state == ST_RESP) && r_write;

    assign db_ready   = r_ready;
    assign db_dataOut = r_dout;

    db_lane_align u_lane (
        .i_addr_lo (w_addr[1:0]),
        .i_len     (w_len),
        .i_wdata   (r_wdata),
        .i_rword   (w_rword),
        .o_be      (w_be),
        .o_wword   (w_wword),
        .o_rdata   (w_rdata)
    );

    // Next-state logic: accept, count wait states, abort on NONE, respond once.
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_latch      = 1'b0;
        w_enter_resp = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_req) begin
                    w_latch = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        w_state_nxt  = ST_RESP;
                        w_enter_resp = 1'b1;
                    end else begin
                        w_state_nxt = ST_WAIT;
                        w_cnt_nxt   = WAIT_INIT;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (db_accessType == ACC_NONE) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = 8'd0;
                end else if (r_cnt == 8'd0) begin
                    w_state_nxt  = ST_RESP;
                    w_enter_resp = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - 8'd1;
                end
            end
            ST_RESP: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = 8'd0;
            end
        endcase
    end

    // Control registers, latched request and read-data/ready outputs.
    always_ff @(posedge clk) begin
        if (res) begin
            r_state <= ST_IDLE;
            r_cnt   <= 8'd0;
            r_ready <= 1'b0;
            r_dout  <= 32'd0;
            r_addr  <= '0;
            r_len   <= LEN_BYTE;
            r_write <= 1'b0;
            r_wdata <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ready <= w_enter_resp;
            if (w_latch) begin
                r_addr  <= db_addr[AW-1:0];
                r_len   <= db_memLen;
                r_write <= (db_accessType == ACC_W);
                r_wdata <= db_dataIn;
            end
            if (w_enter_resp && !w_is_write) begin
                r_dout <= w_rdata;
            end
        end
    end

    // RAM write with byte enables at the edge ending the response cycle;
    // contents survive reset, but a write pending under reset is dropped.
    always_ff @(posedge clk) begin
        if (!res && w_commit) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) begin
                    r_mem[w_idx][8*b +: 8] <= w_wword[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_data_bus_ram_responder.sv
// Directed bench: one responder with two wait states, one with none.
module tb_data_bus_ram_responder;
    import data_bus_ram_responder_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        res;
    logic [31:0] a_addr, a_din, a_dout;
    mem_access_t a_acc;
    mem_len_t    a_len;
    logic        a_ready, a_io;
    logic [31:0] b_addr, b_din, b_dout;
    mem_access_t b_acc;
    mem_len_t    b_len;
    logic        b_ready, b_io;

    int checks = 0;
    int errors = 0;

    data_bus_ram_responder #(.DEPTH_LOG2(12), .WAIT_CYCLES(2)) u_dut_w2 (
        .clk(clk), .res(res), .db_addr(a_addr), .db_dataIn(a_din),
        .db_dataOut(a_dout), .db_accessType(a_acc), .db_memLen(a_len),
        .db_ready(a_ready), .db_io(a_io)
    );

    data_bus_ram_responder #(.DEPTH_LOG2(12), .WAIT_CYCLES(0)) u_dut_w0 (
        .clk(clk), .res(res), .db_addr(b_addr), .db_dataIn(b_din),
        .db_dataOut(b_dout), .db_accessType(b_acc), .db_memLen(b_len),
        .db_ready(b_ready), .db_io(b_io)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One transfer on DUT a (sel=0) or b (sel=1); lat is the cycle index of
    // db_ready counted from the request cycle (0), or -1 if it never came.
    task automatic xfer(input bit sel, input mem_access_t acc, input mem_len_t len,
                        input logic [31:0] addr, input logic [31:0] din, output int lat);
        logic rdy;
        @(posedge clk); #1;
        if (sel) begin
            b_acc = acc; b_len = len; b_addr = addr; b_din = din;
        end else begin
            a_acc = acc; a_len = len; a_addr = addr; a_din = din;
        end
        lat = -1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            rdy = sel ? b_ready : a_ready;
            if (rdy === 1'b1) begin
                lat = k;
                break;
            end
        end
        @(posedge clk); #1;
        if (sel) b_acc = ACC_NONE; else a_acc = ACC_NONE;
        @(negedge clk);
        rdy = sel ? b_ready : a_ready;
        chk("ready_single_pulse", {31'd0, rdy}, 32'd0);
    endtask

    int          lat;
    int          cnt;
    logic [4:0]  rv;
    logic [31:0] d1, d2;

    initial begin
        res = 1'b1;
        a_acc = ACC_NONE; a_len = LEN_WORD; a_addr = 32'd0; a_din = 32'd0;
        b_acc = ACC_NONE; b_len = LEN_WORD; b_addr = 32'd0; b_din = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_ready_a", {31'd0, a_ready}, 32'd0);
        chk("reset_dout_a", a_dout, 32'd0);
        chk("reset_ready_b", {31'd0, b_ready}, 32'd0);
        chk("reset_dout_b", b_dout, 32'd0);
        @(posedge clk); #1 res = 1'b0;

        // Word write then read, two wait states
        xfer(1'b0, ACC_W, LEN_WORD, 32'h100, 32'hDEADBEEF, lat);
        chk("w_word_latency", 32'(lat), 32'd3);
        chk("write_keeps_dout", a_dout, 32'd0);
        xfer(1'b0, ACC_R, LEN_WORD, 32'h100, 32'd0, lat);
        chk("r_word_latency", 32'(lat), 32'd3);
        chk("r_word_data", a_dout, 32'hDEADBEEF);

        // Byte and half lanes
        xfer(1'b0, ACC_W, LEN_BYTE, 32'h102, 32'hFFFFFF5A, lat);
        chk("w_byte_latency", 32'(lat), 32'd3);
        xfer(1'b0, ACC_R, LEN_WORD, 32'h100, 32'd0, lat);
        chk("r_word_after_byte", a_dout, 32'hDE5ABEEF);
        xfer(1'b0, ACC_R, LEN_HALF, 32'h102, 32'd0, lat);
        chk("r_half_upper", a_dout, 32'h0000DE5A);
        xfer(1'b0, ACC_R, LEN_BYTE, 32'h103, 32'd0, lat);
        chk("r_byte_lane3", a_dout, 32'h000000DE);
        xfer(1'b0, ACC_R, LEN_BYTE, 32'h100, 32'd0, lat);
        chk("r_byte_lane0", a_dout, 32'h000000EF);
        xfer(1'b0, ACC_W, LEN_HALF, 32'h101, 32'hABCD1234, lat);
        xfer(1'b0, ACC_R, LEN_WORD, 32'h103, 32'd0, lat);
        chk("r_word_misaligned", a_dout, 32'hDE5A1234);
        xfer(1'b0, ACC_R, LEN_HALF, 32'h103, 32'd0, lat);
        chk("r_half_misaligned", a_dout, 32'h0000DE5A);

        // Aliasing above the RAM depth
        xfer(1'b0, ACC_W, LEN_WORD, 32'h4000, 32'hCAFEF00D, lat);
        chk("alias_write_keeps_dout", a_dout, 32'h0000DE5A);
        xfer(1'b0, ACC_R, LEN_WORD, 32'h0, 32'd0, lat);
        chk("alias_read", a_dout, 32'hCAFEF00D);

        // I/O window: never accepted
        @(posedge clk); #1;
        a_acc = ACC_R; a_len = LEN_WORD; a_addr = 32'hFFFF0010;
        cnt = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (a_io !== 1'b1 || a_ready !== 1'b0) cnt++;
        end
        chk("io_window_bad_cycles", 32'(cnt), 32'd0);
        chk("io_window_dout", a_dout, 32'hCAFEF00D);
        a_acc = ACC_NONE;
        a_addr = 32'hFFFEFFFF; #1;
        chk("io_below_base", {31'd0, a_io}, 32'd0);
        a_addr = 32'hFFFF0000; #1;
        chk("io_at_base", {31'd0, a_io}, 32'd1);

        // Zero wait states, back-to-back R then X
        xfer(1'b1, ACC_W, LEN_WORD, 32'h0, 32'h11223344, lat);
        chk("w0_write_latency", 32'(lat), 32'd1);
        xfer(1'b1, ACC_W, LEN_WORD, 32'h4, 32'hA5A55A5A, lat);
        @(posedge clk); #1;
        b_acc = ACC_R; b_len = LEN_WORD; b_addr = 32'h0;
        @(negedge clk); rv[0] = b_ready;
        @(posedge clk); #1;
        @(negedge clk); rv[1] = b_ready; d1 = b_dout;
        @(posedge clk); #1;
        b_acc = ACC_X; b_addr = 32'h4;
        @(negedge clk); rv[2] = b_ready;
        @(posedge clk); #1;
        @(negedge clk); rv[3] = b_ready; d2 = b_dout;
        @(posedge clk); #1;
        b_acc = ACC_NONE;
        @(negedge clk); rv[4] = b_ready;
        chk("b2b_ready_pattern", {27'd0, rv}, 32'h0000000A);
        chk("b2b_r_data", d1, 32'h11223344);
        chk("b2b_x_data", d2, 32'hA5A55A5A);
        xfer(1'b1, ACC_X, LEN_WORD, 32'h0, 32'd0, lat);
        chk("x_latency", 32'(lat), 32'd1);
        chk("x_same_as_r", b_dout, 32'h11223344);

        // Abort and reset during wait states drop the write
        xfer(1'b0, ACC_W, LEN_WORD, 32'h200, 32'h0BADF00D, lat);
        @(posedge clk); #1;
        a_acc = ACC_W; a_len = LEN_WORD; a_addr = 32'h200; a_din = 32'h12345678;
        @(posedge clk); #1;
        a_acc = ACC_NONE;
        cnt = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (a_ready !== 1'b0) cnt++;
        end
        chk("abort_no_ready", 32'(cnt), 32'd0);
        @(posedge clk); #1;
        a_acc = ACC_W; a_din = 32'h12345678;
        @(posedge clk); #1;
        res = 1'b1;
        @(posedge clk); #1;
        res = 1'b0;
        a_acc = ACC_NONE;
        @(negedge clk);
        chk("ready_after_res", {31'd0, a_ready}, 32'd0);
        cnt = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (a_ready !== 1'b0) cnt++;
        end
        chk("reset_no_ready", 32'(cnt), 32'd0);
        chk("reset_clears_dout", a_dout, 32'd0);
        xfer(1'b0, ACC_R, LEN_WORD, 32'h200, 32'd0, lat);
        chk("post_reset_latency", 32'(lat), 32'd3);
        chk("dropped_writes", a_dout, 32'h0BADF00D);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
